// File: rtl/axilite4_sram_slave.sv
// AXI Lite 4 slave wrapping a single-port 128-bit word memory.
// Serves one transaction at a time with a fixed, parameterised response latency.
module axilite4_sram_slave #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  readAddr_addr,
    input  logic         readAddr_valid,
    output logic         readAddr_ready,
    output logic [127:0] readData_data,
    output logic         readData_valid,
    input  logic         readData_ready,
    input  logic [31:0]  writeAddr_addr,
    input  logic         writeAddr_valid,
    output logic         writeAddr_ready,
    input  logic [127:0] writeData_data,
    input  logic [15:0]  writeData_strb,
    input  logic         writeData_valid,
    output logic         writeData_ready,
    output logic [31:0]  writeResp_msg,
    output logic         writeResp_valid,
    input  logic         writeResp_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_WAIT, W_RESP} state_t;
    typedef enum logic {SRV_READ, SRV_WRITE} served_t;

    state_t        state, stateNext;
    served_t       lastServed;
    logic [CW-1:0] counter;
    logic [AW-1:0] idxReg;
    logic          hitReg;
    logic [127:0]  mem [DEPTH];

    logic [27:0] rdIdx, wrIdx;
    logic        rdHit, wrHit;
    logic        rdReq, wrReq, grantRead, grantWrite;

    always_comb begin
        rdIdx = 28'((readAddr_addr - ADDR_BASE) >> 4);
        wrIdx = 28'((writeAddr_addr - ADDR_BASE) >> 4);
        rdHit = (readAddr_addr >= ADDR_BASE) && ({4'b0, rdIdx} < 32'(DEPTH));
        wrHit = (writeAddr_addr >= ADDR_BASE) && ({4'b0, wrIdx} < 32'(DEPTH));
    end

    // Readies are held low while reset is asserted so nothing is accepted.
    always_comb begin
        rdReq      = readAddr_valid;
        wrReq      = writeAddr_valid & writeData_valid;
        grantRead  = 1'b0;
        grantWrite = 1'b0;
        if (state == IDLE && !rst) begin
            grantRead  = rdReq & (~wrReq | (lastServed == SRV_WRITE));
            grantWrite = wrReq & ~grantRead;
        end
        readAddr_ready  = grantRead;
        writeAddr_ready = grantWrite;
        writeData_ready = grantWrite;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantRead)       stateNext = R_WAIT;
                else if (grantWrite) stateNext = W_WAIT;
            end
            R_WAIT: if (counter == '0) stateNext = R_RESP;
            R_RESP: if (readData_ready) stateNext = IDLE;
            W_WAIT: if (counter == '0) stateNext = W_RESP;
            W_RESP: if (writeResp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastServed      <= SRV_WRITE;
            counter         <= '0;
            idxReg          <= '0;
            hitReg          <= 1'b0;
            readData_data   <= '0;
            readData_valid  <= 1'b0;
            writeResp_msg   <= '0;
            writeResp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantRead) begin
                        idxReg     <= rdIdx[AW-1:0];
                        hitReg     <= rdHit;
                        counter    <= CW'(LATENCY - 1);
                        lastServed <= SRV_READ;
                    end else if (grantWrite) begin
                        idxReg     <= wrIdx[AW-1:0];
                        hitReg     <= wrHit;
                        counter    <= CW'(LATENCY - 1);
                        lastServed <= SRV_WRITE;
                    end
                end
                R_WAIT: begin
                    if (counter == '0) begin
                        readData_data  <= hitReg ? mem[idxReg] : '0;
                        readData_valid <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                R_RESP: begin
                    if (readData_ready) begin
                        readData_data  <= '0;
                        readData_valid <= 1'b0;
                    end
                end
                W_WAIT: begin
                    if (counter == '0) begin
                        writeResp_msg   <= {31'b0, ~hitReg};
                        writeResp_valid <= 1'b1;
                    end else begin
                        counter <= counter - 1'b1;
                    end
                end
                W_RESP: begin
                    if (writeResp_ready) begin
                        writeResp_msg   <= '0;
                        writeResp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory is committed on the accept edge; the latency only delays the response.
    always_ff @(posedge clk) begin
        if (grantWrite && wrHit) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (writeData_strb[i])
                    mem[wrIdx[AW-1:0]][8*i +: 8] <= writeData_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axilite4_sram_slave.sv
// Directed bench for axilite4_sram_slave: hand-computed expectations for
// data paths, strobes, range errors, arbitration, backpressure and reset.
module tb_axilite4_sram_slave;

    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam logic [127:0] D1  = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [127:0] DX  = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    localparam logic [127:0] DY  = 128'h11112222_33334444_55556666_77778888;

    logic         clk, rst;
    logic [31:0]  readAddr_addr;
    logic         readAddr_valid, readAddr_ready;
    logic [127:0] readData_data;
    logic         readData_valid, readData_ready;
    logic [31:0]  writeAddr_addr;
    logic         writeAddr_valid, writeAddr_ready;
    logic [127:0] writeData_data;
    logic [15:0]  writeData_strb;
    logic         writeData_valid, writeData_ready;
    logic [31:0]  writeResp_msg;
    logic         writeResp_valid, writeResp_ready;

    int errCount = 0;
    int checkCount = 0;

    axilite4_sram_slave #(.ADDR_BASE(BASE), .DEPTH(64), .LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .readAddr_addr(readAddr_addr), .readAddr_valid(readAddr_valid), .readAddr_ready(readAddr_ready),
        .readData_data(readData_data), .readData_valid(readData_valid), .readData_ready(readData_ready),
        .writeAddr_addr(writeAddr_addr), .writeAddr_valid(writeAddr_valid), .writeAddr_ready(writeAddr_ready),
        .writeData_data(writeData_data), .writeData_strb(writeData_strb), .writeData_valid(writeData_valid),
        .writeData_ready(writeData_ready),
        .writeResp_msg(writeResp_msg), .writeResp_valid(writeResp_valid), .writeResp_ready(writeResp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic writeTxn(input logic [31:0] addr, input logic [127:0] data, input logic [15:0] strb,
                            output logic [31:0] msg, output int lat);
        int n;
        @(negedge clk);
        writeAddr_addr = addr; writeData_data = data; writeData_strb = strb;
        writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        n = 0;
        #1;
        while (!writeAddr_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!writeAddr_ready) checkVal("wr_accept_timeout", 0, 1);
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        lat = 0;
        while (!writeResp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        msg = writeResp_msg;
        @(negedge clk); writeResp_ready = 1'b1;
        @(posedge clk); #1; writeResp_ready = 1'b0;
    endtask

    task automatic readTxn(input logic [31:0] addr, output logic [127:0] data, output int lat);
        int n;
        @(negedge clk);
        readAddr_addr = addr; readAddr_valid = 1'b1;
        n = 0;
        #1;
        while (!readAddr_ready && n < 20) begin @(negedge clk); #1; n++; end
        if (!readAddr_ready) checkVal("rd_accept_timeout", 0, 1);
        @(posedge clk); #1;
        readAddr_valid = 1'b0;
        lat = 0;
        while (!readData_valid && lat < 20) begin @(posedge clk); #1; lat++; end
        data = readData_data;
        @(negedge clk); readData_ready = 1'b1;
        @(posedge clk); #1; readData_ready = 1'b0;
    endtask

    logic [31:0]  msg;
    logic [127:0] rd;
    int           lat;
    int           n;

    initial begin
        rst = 1'b1;
        readAddr_addr = '0; readAddr_valid = 1'b0; readData_ready = 1'b0;
        writeAddr_addr = '0; writeAddr_valid = 1'b0; writeData_data = '0; writeData_strb = '0;
        writeData_valid = 1'b0; writeResp_ready = 1'b0;
        doReset();
        #1;
        checkVal("rst_rdValid", readData_valid, 0);
        checkVal("rst_rdData", readData_data, 0);
        checkVal("rst_wrValid", writeResp_valid, 0);
        checkVal("rst_wrMsg", writeResp_msg, 0);

        // Write then read with full strobe
        writeTxn(BASE + 32'h20, D1, 16'hFFFF, msg, lat);
        checkVal("wr_lat", lat, 2);
        checkVal("wr_msg_ok", msg, 0);
        readTxn(BASE + 32'h20, rd, lat);
        checkVal("rd_lat", lat, 2);
        checkVal("rd_data", rd, D1);

        // Partial strobe and empty strobe on word 5
        writeTxn(BASE + 32'h50, '1, 16'hFFFF, msg, lat);
        writeTxn(BASE + 32'h50, '0, 16'h000F, msg, lat);
        checkVal("strb_msg", msg, 0);
        readTxn(BASE + 32'h50, rd, lat);
        checkVal("strb_data", rd, {{96{1'b1}}, 32'h0});
        writeTxn(BASE + 32'h50, '0, 16'h0000, msg, lat);
        checkVal("strb0_msg", msg, 0);
        readTxn(BASE + 32'h50, rd, lat);
        checkVal("strb0_data", rd, {{96{1'b1}}, 32'h0});

        // Out of range: neighbours of both ends must stay intact
        writeTxn(BASE, DX, 16'hFFFF, msg, lat);
        writeTxn(BASE + 32'h3F0, DY, 16'hFFFF, msg, lat);
        writeTxn(BASE + 32'h400, D1, 16'hFFFF, msg, lat);
        checkVal("oor_wr_msg", msg, 1);
        checkVal("oor_wr_lat", lat, 2);
        readTxn(BASE, rd, lat);
        checkVal("oor_word0", rd, DX);
        readTxn(BASE + 32'h3F0, rd, lat);
        checkVal("oor_word63", rd, DY);
        readTxn(BASE + 32'h400, rd, lat);
        checkVal("oor_rd_high", rd, 0);
        writeTxn(BASE - 32'h10, D1, 16'hFFFF, msg, lat);
        checkVal("oor_wr_low_msg", msg, 1);
        readTxn(BASE - 32'h10, rd, lat);
        checkVal("oor_rd_low", rd, 0);
        readTxn(BASE + 32'h3F0, rd, lat);
        checkVal("oor_low_word63", rd, DY);

        // Backpressure on read data with a second request pending
        @(negedge clk);
        readAddr_addr = BASE + 32'h20; readAddr_valid = 1'b1;
        @(posedge clk); #1;
        n = 0;
        while (!readData_valid && n < 20) begin @(posedge clk); #1; n++; end
        checkVal("bp_valid_seen", readData_valid, 1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkVal("bp_hold_valid", readData_valid, 1);
            checkVal("bp_hold_data", readData_data, D1);
            checkVal("bp_no_ready", readAddr_ready, 0);
        end
        @(negedge clk); readData_ready = 1'b1;
        @(posedge clk); #1;
        readData_ready = 1'b0;
        checkVal("bp_clr_valid", readData_valid, 0);
        checkVal("bp_clr_data", readData_data, 0);
        checkVal("bp_idle_ready", readAddr_ready, 1);
        readAddr_valid = 1'b0;
        repeat (2) @(posedge clk);

        // Collisions after reset alternate R, W, R, W
        doReset();
        readAddr_addr = BASE + 32'h20;
        writeAddr_addr = BASE + 32'h30; writeData_data = DY; writeData_strb = 16'hFFFF;
        readData_ready = 1'b1; writeResp_ready = 1'b1;
        readAddr_valid = 1'b1; writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!(readAddr_ready || writeAddr_ready) && n < 20) begin @(negedge clk); #1; n++; end
            checkVal("coll_rd_grant", readAddr_ready, (k % 2 == 0));
            checkVal("coll_wr_grant", writeAddr_ready, (k % 2 != 0));
            checkVal("coll_wd_grant", writeData_ready, (k % 2 != 0));
            @(posedge clk); #1;
        end
        readAddr_valid = 1'b0; writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        readData_ready = 1'b0; writeResp_ready = 1'b0;
        readTxn(BASE + 32'h30, rd, lat);
        checkVal("coll_wr_data", rd, DY);

        // Reset while a response is pending clears outputs asynchronously
        @(negedge clk);
        writeAddr_addr = BASE + 32'h400; writeData_data = D1; writeData_strb = 16'hFFFF;
        writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        n = 0;
        while (!writeResp_valid && n < 20) begin @(posedge clk); #1; n++; end
        checkVal("mid_pre_msg", writeResp_msg, 1);
        #2 rst = 1'b1; readAddr_valid = 1'b1;
        #1;
        checkVal("mid_async_valid", writeResp_valid, 0);
        checkVal("mid_async_msg", writeResp_msg, 0);
        checkVal("mid_rst_rdReady", readAddr_ready, 0);
        @(negedge clk); rst = 1'b0;
        readAddr_valid = 1'b0;

        // Reset during W_WAIT drops the response; next read works normally
        @(negedge clk);
        writeAddr_addr = BASE + 32'h40; writeData_data = DX; writeData_strb = 16'hFFFF;
        writeAddr_valid = 1'b1; writeData_valid = 1'b1;
        @(posedge clk); #1;
        writeAddr_valid = 1'b0; writeData_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        checkVal("wwait_rst_valid", writeResp_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkVal("wwait_dropped", writeResp_valid, 0);
        readTxn(BASE + 32'h20, rd, lat);
        checkVal("post_rst_lat", lat, 2);
        checkVal("post_rst_data", rd, D1);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
